// File: rtl/life_pkg.sv
// Shared types and preset pattern table for the life array controller.
// Pattern bits are indexed 4*row+col within each 4x4 quadrant.
package life_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LOAD = 2'd2
  } state_e;

  localparam int NUM_QUADS = 4;

  // First index selects the pattern, second the quadrant.
  localparam logic [15:0] PATTERN [4][4] = '{
    '{16'h0000, 16'h0000, 16'h0000, 16'h0000},
    '{16'h0742, 16'h0000, 16'h0000, 16'h0000},
    '{16'h0070, 16'h0000, 16'h0000, 16'h0000},
    '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}
  };

endpackage

// File: rtl/life_rate_timer.sv
// Generation period counter; tick marks the last cycle of each period.
// The terminal count tracks speed live, so a shorter period takes effect at once.
module life_rate_timer
  import life_pkg::*;
#(
  parameter int PERIOD_BASE = 100000000,
  parameter int CNT_W       = 27
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable_i,
  input  logic       clear_i,
  input  logic [1:0] speed_i,
  output logic       tick_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d, term;

  // A count already past a newly shortened terminal snaps to it first.
  always_comb begin
    term   = CNT_W'((PERIOD_BASE >> speed_i) - 1);
    cnt_d  = cnt_q;
    tick_o = 1'b0;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      if (cnt_q > term) begin
        cnt_d = term;
      end else if (cnt_q == term) begin
        cnt_d  = '0;
        tick_o = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/life_controller.sv
// Sequencer/arbiter for the life array write and step port: run/pause,
// single step, preset loading and user writes, all with registered outputs.
module life_controller
  import life_pkg::*;
#(
  parameter int PERIOD_BASE = 100000000,
  parameter int CNT_W       = 27
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame,
  input  logic        run_btn,
  input  logic        step_btn,
  input  logic        load_req,
  input  logic [1:0]  pattern_sel,
  input  logic [1:0]  speed,
  input  logic        user_write_enb,
  input  logic [15:0] user_val,
  input  logic [1:0]  user_pos,
  output logic        arr_write_enb,
  output logic [15:0] arr_vali,
  output logic [1:0]  arr_vali_selector,
  output logic        arr_step,
  output logic        running,
  output logic        busy,
  output logic [15:0] generation
);

  state_e      state_q;
  logic [1:0]  quad_q, sel_q, quadNext;
  logic        runPrev_q, stepPrev_q, loadPrev_q, stepPending_q;
  logic        wrEnb_q, step_q, running_q, busy_q;
  logic [15:0] vali_q, gen_q;
  logic [1:0]  valiSel_q;
  logic        runEdge, stepEdge, loadEdge, issue, forward;
  logic        timerClear, timerEnable, tick;

  // A user write or a pending load both claim the port ahead of a step.
  always_comb begin
    runEdge     = run_btn  & ~runPrev_q;
    stepEdge    = step_btn & ~stepPrev_q;
    loadEdge    = load_req & ~loadPrev_q;
    issue       = stepPending_q & frame & ~user_write_enb & (state_q != LOAD) & ~loadEdge;
    forward     = user_write_enb & (state_q != LOAD) & ~loadEdge;
    timerClear  = loadEdge | ((state_q == RUN) & runEdge);
    timerEnable = (state_q == RUN);
    quadNext    = quad_q + 2'd1;
  end

  life_rate_timer #(
    .PERIOD_BASE(PERIOD_BASE),
    .CNT_W      (CNT_W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .enable_i(timerEnable),
    .clear_i (timerClear),
    .speed_i (speed),
    .tick_o  (tick)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      quad_q        <= '0;
      sel_q         <= '0;
      runPrev_q     <= 1'b0;
      stepPrev_q    <= 1'b0;
      loadPrev_q    <= 1'b0;
      stepPending_q <= 1'b0;
      wrEnb_q       <= 1'b0;
      vali_q        <= '0;
      valiSel_q     <= '0;
      step_q        <= 1'b0;
      running_q     <= 1'b0;
      busy_q        <= 1'b0;
      gen_q         <= '0;
    end else begin
      runPrev_q  <= run_btn;
      stepPrev_q <= step_btn;
      loadPrev_q <= load_req;
      step_q     <= issue;
      gen_q      <= loadEdge ? 16'd0 : gen_q + {15'd0, step_q};
      wrEnb_q    <= forward;
      vali_q     <= forward ? user_val : 16'd0;
      valiSel_q  <= forward ? user_pos : 2'd0;
      if (loadEdge) begin
        state_q       <= LOAD;
        running_q     <= 1'b0;
        busy_q        <= 1'b1;
        quad_q        <= 2'd0;
        sel_q         <= pattern_sel;
        stepPending_q <= 1'b0;
        wrEnb_q       <= 1'b1;
        vali_q        <= PATTERN[pattern_sel][0];
        valiSel_q     <= 2'd0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (runEdge) begin
              state_q       <= RUN;
              running_q     <= 1'b1;
              stepPending_q <= stepPending_q & ~issue;
            end else begin
              stepPending_q <= (stepPending_q & ~issue) | stepEdge;
            end
          end
          RUN: begin
            if (runEdge) begin
              state_q       <= IDLE;
              running_q     <= 1'b0;
              stepPending_q <= 1'b0;
            end else begin
              stepPending_q <= (stepPending_q & ~issue) | tick;
            end
          end
          LOAD: begin
            // quad_q is the quadrant currently on the outputs.
            if (quad_q == 2'd3) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              quad_q    <= quadNext;
              wrEnb_q   <= 1'b1;
              vali_q    <= PATTERN[sel_q][quadNext];
              valiSel_q <= quadNext;
            end
          end
          default: begin
            state_q   <= IDLE;
            running_q <= 1'b0;
            busy_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign arr_write_enb     = wrEnb_q;
  assign arr_vali          = vali_q;
  assign arr_vali_selector = valiSel_q;
  assign arr_step          = step_q;
  assign running           = running_q;
  assign busy              = busy_q;
  assign generation        = gen_q;

endmodule

// File: doc/life_controller.md
# life_controller

Sequencer and arbiter for the 8x8 life array write/step port. Owns the array's `step`, `write_enb`, `vali` and `vali_selector` inputs. It generates frame-aligned generation steps at a selectable rate, supports run/pause and single-step, and can bulk-load one of four preset patterns. User quadrant writes are arbitrated against the loader and the stepper. It sits between the board inputs, the VESA driver's `frame` pulse and `life_array_8x8`.

## Interface
- `PERIOD_BASE`, 100000000: clk cycles per generation at speed 0.
- `CNT_W`, 27: width of the period counter; must hold `PERIOD_BASE`-1.
- `clk` input 1: system clock.
- `reset` input 1: synchronous, active-low reset.
- `frame` input 1: one-cycle pulse from the VESA driver at end of frame.
- `run_btn` input 1: level input, already debounced; each rising edge toggles run/pause.
- `step_btn` input 1: level input; a rising edge while paused requests one step.
- `load_req` input 1: level input; a rising edge starts a pattern load.
- `pattern_sel` input 2: preset pattern index, sampled on the `load_req` edge.
- `speed` input 2: generation period is `PERIOD_BASE >> speed`; sampled continuously.
- `user_write_enb` input 1: user quadrant write request, one cycle.
- `user_val` input 16: user quadrant data.
- `user_pos` input 2: user quadrant index.
- `arr_write_enb` output 1: array write strobe.
- `arr_vali` output 16: array write data.
- `arr_vali_selector` output 2: array quadrant index.
- `arr_step` output 1: one-cycle generation step.
- `running` output 1: high in state RUN.
- `busy` output 1: high in state LOAD.
- `generation` output 16: count of steps issued since the last load or reset.

## Operation
- All outputs are registered. Under reset every output is 0, the state is IDLE, and the counter, step_pending and edge-detector history are all 0.
- Edge detect: the block keeps a one-cycle history of `run_btn`, `step_btn` and `load_req`. An edge is `in & ~prev`.
- States:
  - IDLE (paused): a run edge moves to RUN. A step edge sets step_pending.
  - RUN: the period counter increments every cycle. When it reaches `(PERIOD_BASE>>speed)-1`, the counter returns to 0 and step_pending is set. A run edge returns to IDLE and clears the counter and step_pending.
  - LOAD: lasts exactly 4 cycles, writing quadrants 0,1,2,3 in order with `arr_write_enb`=1 and data `PATTERN[pattern_sel][q]`. It then enters IDLE.
- Transition priority: a load edge wins from any state, including LOAD itself, which restarts at quadrant 0. Next comes the run edge, then the step edge.
- Entering LOAD clears step_pending, the counter and `generation`.
- Step issue: `arr_step` pulses in the cycle after a cycle in which all of the following hold:
  - step_pending=1;
  - `frame`=1;
  - `user_write_enb`=0;
  - state is not LOAD.
- step_pending clears when the step issues. A step that becomes pending again before it issues merges with the existing one, so at most one step is issued per frame.
- Arbitration:
  - A user write is forwarded, with one cycle of latency, in IDLE or RUN.
  - A user write is dropped during LOAD and on the cycle a load edge is taken.
  - A write coinciding with a step-eligible frame wins; that step waits for the next frame.
  - `arr_step` and `arr_write_enb` are never high in the same cycle.
- `generation` increments by 1 on each `arr_step` and wraps from 16'hFFFF to 0.
- When `arr_write_enb`=0, `arr_vali` and `arr_vali_selector` hold 0.

## Timing
- User write: request at cycle N produces the array write at N+1.
- Load: edge at N; quadrants 0..3 are written at N+1..N+4; `busy` is high N+1..N+4; `running`=0 from N+1.
- Step: `frame` at N with step pending produces `arr_step` at N+1 and `generation` updated at N+2.
- The worst-case delay from the period elapsing to the step is one frame.
- Changing `speed` mid-count: if the counter already exceeds the new terminal count, it saturates to terminal next cycle, producing an immediate pending step, then resumes from 0.
- A reset asserted mid-LOAD aborts the load; all outputs are 0 on the next edge.

## Structure
- Package `life_pkg`:
  - state enum `{IDLE, RUN, LOAD}`;
  - `PATTERN[4][4]` 16-bit constants. Bit index is `4*row+col` within a quadrant.
  - Pattern 0 (clear): all quadrants 0.
  - Pattern 1 (glider): quadrant 0 = 16'h0742, others 0.
  - Pattern 2 (blinker): quadrant 0 = 16'h0070, others 0.
  - Pattern 3 (full): all quadrants 16'hFFFF.
- Sub-module `life_rate_timer`: holds the period counter, terminal-count compare from `speed`, and the `tick` output. Everything else stays in `life_controller`.

## Test plan
Use `PERIOD_BASE`=16 and a `frame` pulse every 5 cycles.
- Reset then load: `pattern_sel`=1 with a `load_req` edge gives writes (0,16'h0742), (1,0), (2,0), (3,0) on 4 consecutive cycles. `busy`=1 for exactly 4 cycles, and `generation`=0 afterwards.
- Run at speed 0 for 160 cycles: `arr_step` pulses are each aligned 1 cycle after a `frame`, spaced 15–20 cycles apart. `generation`=9 or 10, and stepping stops within 1 cycle of the pause edge.
- Paused single step: one `step_btn` edge gives exactly one `arr_step`, at the next frame+1. Holding `step_btn` high gives no further steps.
- Conflict: assert `user_write_enb` with `user_pos`=2 and `user_val`=16'hA5A5 on a step-eligible frame cycle. The write appears next cycle, and `arr_step` defers to the following frame; the two strobes are never simultaneous.
- Load during RUN with a step pending: no `arr_step` occurs, user writes during LOAD are dropped, and the block ends in IDLE with `running`=0.
- Reset mid-load after quadrant 1: all outputs are 0 next cycle, and no further writes occur.
